// File: rtl/packet_uart_tx_pkg.sv
// packet_uart_tx shared types: UART state encoding,
// frame geometry and baud divider derivation.
package packet_uart_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_t;

  localparam int UART_FRAME_BITS = 10;
  localparam int UART_DATA_BITS  = UART_FRAME_BITS - 2;

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/packet_uart_tx_if.sv
// packet_uart_tx request bundle: packet + start in,
// busy + done back to the packet source.
interface packet_uart_tx_if #(
  parameter int PACKET_BYTES = 22
);

  logic [PACKET_BYTES*8-1:0] packet;
  logic                      start;
  logic                      busy;
  logic                      done;

  modport master (
    output packet,
    output start,
    input  busy,
    input  done
  );

  modport slave (
    input  packet,
    input  start,
    output busy,
    output done
  );

endinterface

// File: rtl/packet_uart_tx_byte_tx.sv
// uart_byte_tx: one 8N1 frame per load; ready rises in the
// last stop-bit cycle so back-to-back loads leave no gap.
module uart_byte_tx
  import packet_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       load,
  output logic       ready,
  output logic       txd
);

  localparam int DIV_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST =
    3'(UART_DATA_BITS - 1);

  uart_state_t      state;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_idx;
  logic [7:0]       sh;
  logic             bit_end;

  assign bit_end = div == DIV_LAST;
  assign ready   = (state == S_IDLE) ||
                   ((state == S_STOP) && bit_end);

  // Bit-timing FSM; txd is registered alongside state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      div     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      txd     <= 1'b1;
    end else if (load && ready) begin
      state   <= S_START;
      div     <= '0;
      bit_idx <= '0;
      sh      <= tx_byte;
      txd     <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == S_START): begin
          if (bit_end) begin
            div   <= '0;
            state <= S_DATA;
            txd   <= sh[0];
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        (state == S_DATA): begin
          if (bit_end) begin
            div <= '0;
            if (bit_idx == BIT_LAST) begin
              state <= S_STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              sh      <= {1'b0, sh[7:1]};
              txd     <= sh[1];
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        (state == S_STOP): begin
          if (bit_end) begin
            div   <= '0;
            state <= S_IDLE;
          end else begin
            div <= div + DIV_W'(1);
          end
          txd <= 1'b1;
        end
        default: begin
          div <= '0;
          txd <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/packet_uart_tx.sv
// packet_uart_tx: latches a packet and streams it MSB byte first
// as 8N1 bytes. PACKET_UART_TX_CHECKSUM_EN appends an XOR byte.
module packet_uart_tx
  import packet_uart_tx_pkg::*;
#(
  parameter int CLK_HZ       = 100000000,
  parameter int BAUD         = 115200,
  parameter int PACKET_BYTES = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  packet_uart_tx_if.slave         bus,
  output logic                    TxD
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int W   = PACKET_BYTES * 8;
`ifdef PACKET_UART_TX_CHECKSUM_EN
  localparam int LAST = PACKET_BYTES;
`else
  localparam int LAST = PACKET_BYTES - 1;
`endif
  localparam int CNT_W = (LAST > 0) ? $clog2(LAST + 1) : 1;

  logic [W-1:0]     sh;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic             tx_ready;
  logic             accept;
  logic             last;
  logic             advance;
  logic             finish;
  logic             load;
  logic [7:0]       tx_byte;
  logic [7:0]       pkt_top;
  logic [7:0]       sh_top;

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  assign pkt_top = bus.packet[W-1 -: 8];
  assign sh_top  = sh[W-1 -: 8];
  assign accept  = !busy_q && bus.start;
  assign last    = cnt == CNT_W'(LAST);
  assign advance = busy_q && tx_ready && !last;
  assign finish  = busy_q && tx_ready && last;
  assign load    = accept || advance;

`ifdef PACKET_UART_TX_CHECKSUM_EN
  logic [7:0] chk;
  logic       chk_slot;

  assign chk_slot = cnt == CNT_W'(PACKET_BYTES - 1);
  assign tx_byte  = accept   ? pkt_top :
                    chk_slot ? chk     : sh_top;

  // Running XOR of every packet byte as it is handed over.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk <= '0;
    end else if (accept) begin
      chk <= pkt_top;
    end else if (advance && !chk_slot) begin
      chk <= chk ^ sh_top;
    end
  end
`else
  assign tx_byte = accept ? pkt_top : sh_top;
`endif

  // Byte sequencer: latch on accept, feed one byte per ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
      sh     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        accept: begin
          busy_q <= 1'b1;
          cnt    <= '0;
          sh     <= {bus.packet[W-9:0], 8'h00};
        end
        advance: begin
          cnt <= cnt + CNT_W'(1);
          sh  <= {sh[W-9:0], 8'h00};
        end
        finish: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CPB)
  ) u_byte_tx (
    .clk    (clk),
    .rst    (rst),
    .tx_byte(tx_byte),
    .load   (load),
    .ready  (tx_ready),
    .txd    (TxD)
  );

endmodule

// File: doc/packet_uart_tx.md
Name: packet_uart_tx

Overview:
- Downstream consumer of the 176-bit game-state packet produced by the packet assembler.
- Serialises the packet as consecutive UART 8N1 bytes onto the board TxD line for the host-side renderer.
- Sits between the packet assembler and the top-level TxD pin.
- The game-speed logic drives a start strobe each frame. The block latches the packet so that packet-source updates mid-transmission cannot tear a frame.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits per second.
- PACKET_BYTES, 22, number of bytes in the packet; the packet width is PACKET_BYTES*8.

Ports:
- clk  input  1  system clock; all logic on rising edge; single clock domain.
- rst  input  1  synchronous, active-high reset.
- packet  input  PACKET_BYTES*8  game-state packet; sampled only when start is accepted.
- start  input  1  request to send one frame; level is sampled each cycle.
- busy  output  1  high from the cycle after start is accepted until the last stop bit completes.
- done  output  1  single-cycle pulse when the frame has fully left the line.
- TxD  output  1  UART line; idles high.

Behaviour:
- Reset values:
  - TxD=1, busy=0, done=0.
  - State IDLE; bit counter, byte counter and divider all 0.
  - Reset mid-frame aborts the frame: TxD is high on the cycle after rst is sampled, and there is no resume.
- Divider:
  - CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated; 868 at the defaults.
  - Every bit, including start and stop, lasts exactly CLKS_PER_BIT cycles.
  - The divider counter is wide enough for CLKS_PER_BIT-1 and wraps to 0 at bit end.
- Start acceptance:
  - start is accepted in any cycle with busy=0, including the cycle done is high.
  - On acceptance, packet is copied to an internal shift register and busy=1 on the next cycle.
  - TxD drives the first start bit (0) on that same next cycle. Latency from start to line activity is 1 cycle.
  - start while busy=1 is ignored; there is no queueing.
- Byte order: byte 0 is packet[PACKET_BYTES*8-1 -: 8] (MSB byte first), proceeding toward packet[7:0].
- Bit order within a byte: LSB first.
- State machine:
  - IDLE -> START on accepted start.
  - START (TxD=0, 1 bit time) -> DATA.
  - DATA (8 bit times, bit index 0..7) -> STOP.
  - STOP (TxD=1, 1 bit time):
    - -> START if more bytes remain; there is no idle gap between bytes.
    - -> IDLE if the last byte is done. done=1 and busy=0 in the first IDLE cycle.
- Frame length: PACKET_BYTES*10*CLKS_PER_BIT cycles from the first start bit to the end of the last stop bit.
- The byte counter spans 0..PACKET_BYTES-1, plus 1 when the optional feature is enabled. No wrap occurs inside a frame.
- Changes on packet while busy have no effect on the transmitted data.

Optional Feature:
- Macro PACKET_UART_TX_CHECKSUM_EN.
- Defined:
  - An extra trailing byte is sent after byte PACKET_BYTES-1: the XOR of all PACKET_BYTES packet bytes, computed incrementally as bytes are loaded.
  - Frame length becomes (PACKET_BYTES+1)*10*CLKS_PER_BIT cycles, and done is delayed accordingly.
- Undefined: exactly PACKET_BYTES bytes are sent; no checksum logic is present.

Decomposition:
- Shared package: state encoding (IDLE, START, DATA, STOP), UART_FRAME_BITS=10, and the CLKS_PER_BIT derivation helper.
- Natural sub-module: uart_byte_tx.
  - Interface: byte in, load strobe, ready, TxD out; one 8N1 frame per load.
  - packet_uart_tx is the byte sequencer around it.
  - Back-to-back loads must produce no idle cycle between frames.

Test Plan:
All scenarios use CLK_HZ=1000, BAUD=100 (10 clocks per bit) and PACKET_BYTES=22.
- Reset then idle 50 cycles -> TxD=1, busy=0, done=0 throughout.
- packet byte 0 = 0xA5, others 0x00, one-cycle start -> TxD low on cycle 1 for 10 cycles. Byte 0 bits, LSB first, are 1,0,1,0,0,1,0,1, each 10 cycles, then stop high. The full frame is 2200 cycles, done pulses exactly once at cycle 2201, and a UART monitor decodes 22 bytes equal to packet.
- start held high continuously with packet changed every cycle after acceptance -> the second frame begins in the done cycle. The first frame decodes to the value latched at acceptance; the second frame decodes to the value present in the done cycle.
- start pulse at cycle 500 of a frame -> ignored; done pulses once; the total byte count is 22.
- rst asserted at cycle 735 mid-DATA -> TxD=1 and busy=0 next cycle, no done pulse. A new start afterwards sends a clean 22-byte frame.
- With PACKET_UART_TX_CHECKSUM_EN and packet bytes 0x01..0x16 -> 23 bytes decoded, the last byte = 0x17 (XOR of 0x01..0x16), and done at cycle 2301.
